// File: rtl/mem_stage_dcache.sv
// ----------------------------------------------------------------------------
// mem_stage_dcache
//   MEM-stage data cache. It is direct-mapped, write-through and
//   no-write-allocate, with 4-word lines. A load hit completes in the same
//   cycle. A load miss refills the whole line from a word-wide memory port.
//   Every store is written through to memory as a single beat. If the store
//   hits the cache, the cached word is updated as well.
//
// Ports
//   clk, rst_n          clock; asynchronous active-low reset
//   MemRead, MemWrite   request from EX_MEM (MemWrite wins if both are set)
//   address, writeData  byte address (bits [1:0] ignored) and store data
//   hit                 1 = access complete or no access; 0 = hold pipeline
//   readData            load data, valid while hit=1 on a load
//   mem_req, mem_we     registered memory request / write-beat flag
//   mem_addr, mem_wdata registered word-aligned address and write data
//   mem_ready           beat accepted this cycle (read data valid with it)
//   mem_rdata           read beat data
//   state_dbg           current FSM state (IDLE=0, REFILL=1, WRITE=2, DONE=3)
//
// Handshake: a memory beat transfers on a rising edge where mem_req and
// mem_ready are both 1. While mem_req=1 and mem_ready=0, the cache holds
// mem_addr, mem_we and mem_wdata stable. mem_ready is ignored while
// mem_req=0. On the pipeline side, hit=0 asks the pipeline to keep MemRead,
// MemWrite, address and writeData stable.
// ----------------------------------------------------------------------------
module mem_stage_dcache #(
    parameter int SIZE  = 32,
    parameter int LINES = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            MemRead,
    input  logic            MemWrite,
    input  logic [SIZE-1:0] address,
    input  logic [SIZE-1:0] writeData,
    output logic            hit,
    output logic [SIZE-1:0] readData,
    output logic            mem_req,
    output logic            mem_we,
    output logic [SIZE-1:0] mem_addr,
    output logic [SIZE-1:0] mem_wdata,
    input  logic            mem_ready,
    input  logic [SIZE-1:0] mem_rdata,
    output logic [1:0]      state_dbg
);

    localparam int INDEX_W = $clog2(LINES);
    localparam int TAG_W   = SIZE - 4 - INDEX_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        WRITE  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [SIZE-1:0]  data_q [LINES][4];
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [LINES-1:0] valid_q;
    logic [1:0]       beat_q;

    // Request-side address fields (used for the IDLE lookup).
    logic [1:0]         req_word;
    logic [INDEX_W-1:0] req_index;
    logic [TAG_W-1:0]   req_tag;
    logic               lookup_hit;

    // Memory-side fields. The line being refilled or written is taken from
    // the registered mem_addr, so array updates depend only on state that the
    // cache owns.
    logic [INDEX_W-1:0] mem_index;
    logic [TAG_W-1:0]   mem_tag;
    logic               write_hit;

    logic start_refill, start_write, beat_accept, write_accept, refill_last;

    // Address bits [1:0] are a byte offset that this word cache never uses.
    logic unused_byte_bits;
    assign unused_byte_bits = ^address[1:0];

    assign req_word   = address[3:2];
    assign req_index  = address[3+INDEX_W:4];
    assign req_tag    = address[SIZE-1:4+INDEX_W];
    assign lookup_hit = valid_q[req_index] && (tag_q[req_index] == req_tag);

    assign mem_index  = mem_addr[3+INDEX_W:4];
    assign mem_tag    = mem_addr[SIZE-1:4+INDEX_W];
    assign write_hit  = valid_q[mem_index] && (tag_q[mem_index] == mem_tag);

    assign refill_last = beat_accept && (beat_q == 2'd3);
    assign state_dbg   = state_q;

    // Next state, pipeline-facing outputs and one-cycle action strobes.
    always_comb begin
        state_d      = state_q;
        hit          = 1'b0;
        readData     = '0;
        start_refill = 1'b0;
        start_write  = 1'b0;
        beat_accept  = 1'b0;
        write_accept = 1'b0;
        case (state_q)
            IDLE: begin
                if (MemWrite) begin
                    start_write = 1'b1;
                    state_d     = WRITE;
                end else if (MemRead) begin
                    if (lookup_hit) begin
                        hit      = 1'b1;
                        readData = data_q[req_index][req_word];
                    end else begin
                        start_refill = 1'b1;
                        state_d      = REFILL;
                    end
                end else begin
                    hit = 1'b1;
                end
            end
            REFILL: begin
                if (mem_req && mem_ready) begin
                    beat_accept = 1'b1;
                    if (beat_q == 2'd3) begin
                        state_d = IDLE;
                    end
                end
            end
            WRITE: begin
                if (mem_req && mem_ready) begin
                    write_accept = 1'b1;
                    state_d      = DONE;
                end
            end
            DONE: begin
                // One-cycle release so that the pipeline advances past the
                // store before a new request is considered.
                hit     = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state and the memory port registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            beat_q    <= 2'd0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            valid_q   <= '0;
        end else begin
            state_q <= state_d;
            if (start_refill) begin
                beat_q   <= 2'd0;
                mem_req  <= 1'b1;
                mem_we   <= 1'b0;
                mem_addr <= {address[SIZE-1:4], 4'b0000};
            end else if (start_write) begin
                mem_req   <= 1'b1;
                mem_we    <= 1'b1;
                mem_addr  <= {address[SIZE-1:2], 2'b00};
                mem_wdata <= writeData;
            end else if (beat_accept) begin
                // The counter wraps 3->0 only here, at the end of the refill.
                beat_q <= beat_q + 2'd1;
                if (beat_q == 2'd3) begin
                    mem_req <= 1'b0;
                end else begin
                    mem_addr[3:2] <= beat_q + 2'd1;
                end
            end else if (write_accept) begin
                mem_req <= 1'b0;
                mem_we  <= 1'b0;
            end
            // The line becomes valid only once all four words are present.
            // This means an aborted refill leaves it invalid.
            if (refill_last) begin
                valid_q[mem_index] <= 1'b1;
            end
        end
    end

    // Data and tag storage are not reset. Only the valid bits are cleared.
    always_ff @(posedge clk) begin
        if (beat_accept) begin
            data_q[mem_index][beat_q] <= mem_rdata;
        end
        if (refill_last) begin
            tag_q[mem_index] <= mem_tag;
        end
        if (write_accept && write_hit) begin
            data_q[mem_index][mem_addr[3:2]] <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_mem_stage_dcache.sv
module tb_mem_stage_dcache;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] writeData = '0;
    logic        hit;
    logic [31:0] readData;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic [1:0]  state_dbg;

    mem_stage_dcache #(.SIZE(32), .LINES(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .address   (address),
        .writeData (writeData),
        .hit       (hit),
        .readData  (readData),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .state_dbg (state_dbg)
    );

    // ---------------- checking ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- memory + reference model ----------------
    logic [31:0] mem_m [logic [31:0]];   // memory behind the port, written by real write beats
    logic [31:0] ref_m [logic [31:0]];   // what a load must return, written by the bench
    bit          m_valid [16];
    logic [23:0] m_tag   [16];

    function automatic logic [31:0] init_word(input logic [31:0] wa);
        return wa ^ 32'h5A5A_C3C3;
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] wa);
        if (mem_m.exists(wa)) return mem_m[wa];
        return init_word(wa);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] wa);
        if (ref_m.exists(wa)) return ref_m[wa];
        return init_word(wa);
    endfunction

    // Expected memory beats, in order.
    logic [31:0] exp_q[$];
    logic [31:0] exp_we_q[$];
    logic [31:0] exp_wd_q[$];

    // Monitor: an accepted beat must be the next expected one.
    always @(posedge clk) begin
        if (rst_n && mem_req && mem_ready) begin
            check("beat_expected", {31'b0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                logic [31:0] ea, ew, ed;
                ea = exp_q.pop_front();
                ew = exp_we_q.pop_front();
                ed = exp_wd_q.pop_front();
                check("beat_addr", mem_addr, ea);
                check("beat_we", {31'b0, mem_we}, ew);
                if (ew[0]) check("beat_wdata", mem_wdata, ed);
            end
            if (mem_we) mem_m[mem_addr] = mem_wdata;
        end
    end

    // Responder: ready after a fixed number of wait cycles (fixed_d >= 0) or a
    // random 0..2. It also checks that a pending beat is held stable.
    int          fixed_d = 0;
    int          rand_d = 0;
    int          wait_cnt = 0;
    int          eff_d;
    bit          prev_pending = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [31:0] prev_wdata = '0;
    logic        prev_we = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_pending = 1'b0;
            mem_ready    = 1'b0;
            wait_cnt     = 0;
        end else begin
            if (prev_pending) begin
                check("hold_req", {31'b0, mem_req}, 32'd1);
                check("hold_addr", mem_addr, prev_addr);
                check("hold_we", {31'b0, mem_we}, {31'b0, prev_we});
                if (prev_we) check("hold_wdata", mem_wdata, prev_wdata);
            end
            eff_d = (fixed_d >= 0) ? fixed_d : rand_d;
            if (mem_req && wait_cnt >= eff_d) begin
                mem_ready = 1'b1;
                wait_cnt  = 0;
                rand_d    = $urandom_range(0, 2);
            end else begin
                mem_ready = 1'b0;
                if (mem_req) wait_cnt++;
            end
            mem_rdata    = mem_rd(mem_addr);
            prev_pending = mem_req && !mem_ready;
            prev_addr    = mem_addr;
            prev_wdata   = mem_wdata;
            prev_we      = mem_we;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check_idle();
        check("idle_hit", {31'b0, hit}, 32'd1);
        check("idle_rdata", readData, 32'd0);
        check("idle_req", {31'b0, mem_req}, 32'd0);
    endtask

    task automatic do_read(input logic [31:0] a);
        logic [31:0] wa;
        int          idx;
        logic [23:0] tg;
        bit          pred_hit;
        int          cyc;
        wa  = {a[31:2], 2'b00};
        idx = int'(a[7:4]);
        tg  = a[31:8];
        pred_hit = m_valid[idx] && (m_tag[idx] == tg);
        if (!pred_hit) begin
            for (int w = 0; w < 4; w++) begin
                exp_q.push_back({a[31:4], w[1:0], 2'b00});
                exp_we_q.push_back(32'd0);
                exp_wd_q.push_back(32'd0);
            end
        end
        address  = a;
        MemWrite = 1'b0;
        MemRead  = 1'b1;
        #1;
        check("rd_hit_now", {31'b0, hit}, {31'b0, pred_hit});
        if (pred_hit) begin
            check("rd_hit_data", readData, ref_rd(wa));
            check("rd_hit_no_req", {31'b0, mem_req}, 32'd0);
        end else begin
            check("rd_miss_rdata0", readData, 32'd0);
            cyc = 0;
            while (!hit && cyc < 300) begin
                @(posedge clk);
                #1;
                cyc++;
            end
            check("rd_miss_done", {31'b0, hit}, 32'd1);
            check("rd_miss_beats_left", exp_q.size(), 32'd0);
            check("rd_miss_data", readData, ref_rd(wa));
            check("rd_miss_req_off", {31'b0, mem_req}, 32'd0);
            if (fixed_d >= 0) check("rd_miss_latency", cyc, 1 + 4 * (fixed_d + 1));
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tg;
        end
        MemRead = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] wa;
        int          cyc;
        wa = {a[31:2], 2'b00};
        exp_q.push_back(wa);
        exp_we_q.push_back(32'd1);
        exp_wd_q.push_back(d);
        address   = a;
        writeData = d;
        MemWrite  = 1'b1;
        MemRead   = 1'($urandom_range(0, 1));   // a store must win over a load
        #1;
        check("wr_stall", {31'b0, hit}, 32'd0);
        cyc = 0;
        while (!hit && cyc < 300) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("wr_done_hit", {31'b0, hit}, 32'd1);
        check("wr_beats_left", exp_q.size(), 32'd0);
        check("wr_done_rdata", readData, 32'd0);
        check("wr_req_off", {31'b0, mem_req}, 32'd0);
        check("wr_we_off", {31'b0, mem_we}, 32'd0);
        if (fixed_d >= 0) check("wr_latency", cyc, fixed_d + 2);
        ref_m[wa] = d;
        MemWrite  = 1'b0;
        MemRead   = 1'b0;
        @(posedge clk);
        #1;
        check_idle();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_hit", {31'b0, hit}, 32'd1);
        check("rst_rdata", readData, 32'd0);
        check("rst_req", {31'b0, mem_req}, 32'd0);
        check("rst_we", {31'b0, mem_we}, 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_idle();

        fixed_d = 0;
        // first miss and a hit on the same line
        do_read(32'h0000_0100);
        do_read(32'h0000_0104);
        // write hit, then a read of the updated word
        do_write(32'h0000_0108, 32'hDEAD_BEEF);
        do_read(32'h0000_0108);
        // index conflict evicts the line
        do_read(32'h0000_0500);
        do_read(32'h0000_0100);
        do_read(32'h0000_0108);
        // write miss: no allocation
        do_write(32'h0000_2000, 32'h1234_5678);
        do_read(32'h0000_2000);
        // slow memory
        fixed_d = 3;
        do_read(32'h0000_3040);
        do_write(32'h0000_3044, 32'hCAFE_F00D);
        do_read(32'h0000_3044);
        fixed_d = 0;

        // reset in the middle of a refill
        for (int w = 0; w < 4; w++) begin
            exp_q.push_back({28'h0000_070, w[1:0], 2'b00});
            exp_we_q.push_back(32'd0);
            exp_wd_q.push_back(32'd0);
        end
        address = 32'h0000_0700;
        MemRead = 1'b1;
        for (int c = 0; c < 50 && exp_q.size() > 2; c++) begin
            @(posedge clk);
            #1;
        end
        check("abort_two_beats_done", exp_q.size(), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_req_drop", {31'b0, mem_req}, 32'd0);
        check("abort_we", {31'b0, mem_we}, 32'd0);
        check("abort_addr", mem_addr, 32'd0);
        MemRead = 1'b0;
        exp_q.delete();
        exp_we_q.delete();
        exp_wd_q.delete();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_idle();
        do_read(32'h0000_0700);
        do_read(32'h0000_0704);

        // randomized mix over a few tags and indices
        fixed_d = -1;
        for (int n = 0; n < 80; n++) begin
            logic [31:0] a;
            logic [23:0] tg;
            case ($urandom_range(0, 2))
                0:       tg = 24'h000001;
                1:       tg = 24'h000005;
                default: tg = 24'h0000AB;
            endcase
            a = {tg, 4'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            if ($urandom_range(0, 99) < 40) do_write(a, $urandom);
            else do_read(a);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Watchdog.
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
